// File: rtl/maxnet_pkg.sv
// ---------------------------------------------------------------------------
// maxnet_pkg
// Shared definitions for the max-finder batch driver:
//   NEURON_W     - default bit width of one neuron value
//   NUM_NEURONS  - number of neuron values that make up one vector
//   state_t      - sequencing FSM states of the driver
//   vec_t        - one packed input vector (neuron 1 in the lowest slot)
// ---------------------------------------------------------------------------
package maxnet_pkg;

   localparam int NEURON_W    = 5;
   localparam int NUM_NEURONS = 4;

   // IDLE waits for a queued vector, CLR resets the core, SETUP presents the
   // values, START pulses the core and WAIT watches for done or the timeout.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SETUP = 3'd2,
      START = 3'd3,
      WAIT  = 3'd4
   } state_t;

   typedef logic [NUM_NEURONS-1:0][NEURON_W-1:0] vec_t;

endpackage

// File: rtl/maxnet_batch_driver_if.sv
// ---------------------------------------------------------------------------
// maxnet_batch_driver_if
// Bundles every handshake and data signal of the batch driver:
//   upstream  : in_valid, in_ready, in_neuron1..in_neuron4
//   core side : core_rst, core_start, Neuron1..Neuron4, core_done, core_max
//   result    : res_valid, res_ready, res_max, res_err
// Modports:
//   master - the driver itself
//   slave  - the surrounding environment (vector source, core, result sink)
// ---------------------------------------------------------------------------
interface maxnet_batch_driver_if
   import maxnet_pkg::*;
#(
   parameter int WIDTH = NEURON_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_neuron1;
   logic [WIDTH-1:0] in_neuron2;
   logic [WIDTH-1:0] in_neuron3;
   logic [WIDTH-1:0] in_neuron4;

   logic             core_rst;
   logic             core_start;
   logic [WIDTH-1:0] Neuron1;
   logic [WIDTH-1:0] Neuron2;
   logic [WIDTH-1:0] Neuron3;
   logic [WIDTH-1:0] Neuron4;
   logic             core_done;
   logic [WIDTH-1:0] core_max;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_max;
   logic             res_err;

   modport master (
      input  in_valid, in_neuron1, in_neuron2, in_neuron3, in_neuron4,
      output in_ready,
      output core_rst, core_start, Neuron1, Neuron2, Neuron3, Neuron4,
      input  core_done, core_max,
      output res_valid, res_max, res_err,
      input  res_ready
   );

   modport slave (
      output in_valid, in_neuron1, in_neuron2, in_neuron3, in_neuron4,
      input  in_ready,
      input  core_rst, core_start, Neuron1, Neuron2, Neuron3, Neuron4,
      output core_done, core_max,
      input  res_valid, res_max, res_err,
      output res_ready
   );

endinterface

// File: rtl/maxnet_vec_fifo.sv
// ---------------------------------------------------------------------------
// maxnet_vec_fifo
// Synchronous FIFO holding DEPTH vectors of NUM_NEURONS*WIDTH bits.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//   push, din    - write request and data (ignored while full)
//   pop, dout    - read request (ignored while empty) and current head
//   full, empty  - registered occupancy flags
// ---------------------------------------------------------------------------
module maxnet_vec_fifo
   import maxnet_pkg::*;
#(
   parameter int WIDTH = NEURON_W,
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [NUM_NEURONS*WIDTH-1:0] din,
   input  logic                         pop,
   output logic [NUM_NEURONS*WIDTH-1:0] dout,
   output logic                         full,
   output logic                         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = NUM_NEURONS * WIDTH;
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          do_push;
   logic          do_pop;

   // Both requests are qualified by the registered flags, so a pop in the
   // same cycle never makes room for a push while the FIFO reads full.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Occupancy after this cycle; a simultaneous push and pop cancel out.
   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage array carries no reset; only entries between the pointers matter.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == FULL_COUNT);
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/maxnet_batch_driver.sv
// ---------------------------------------------------------------------------
// maxnet_batch_driver
// Initiator for the max-finder core's start/done handshake. Queues vectors
// of four neuron values and, one at a time, resets the core, presents the
// values, pulses start, waits for done (or a timeout) and hands the maximum
// to a valid/ready result port.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, also forces core_rst high
//   bus    - maxnet_batch_driver_if.master (upstream, core and result signals)
//   stat_done_cnt[15:0], stat_timeout_cnt[7:0]
//          - only when MAXNET_DRV_STATS_EN is defined: wrapping count of
//            successful captures and saturating count of timeouts
// Parameters:
//   WIDTH   - neuron / result width
//   DEPTH   - vector FIFO depth (power of two, at least 2)
//   TIMEOUT - WAIT cycles allowed before the transaction is aborted
// ---------------------------------------------------------------------------
module maxnet_batch_driver
   import maxnet_pkg::*;
#(
   parameter int WIDTH   = NEURON_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   maxnet_batch_driver_if.master bus
`ifdef MAXNET_DRV_STATS_EN
   ,
   output logic [15:0]           stat_done_cnt,
   output logic [7:0]            stat_timeout_cnt
`endif
);

   localparam int DW = NUM_NEURONS * WIDTH;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

   state_t           state;
   logic [DW-1:0]    vec_reg;
   logic [DW-1:0]    drive_vec;
   logic [DW-1:0]    fifo_dout;
   logic [DW-1:0]    fifo_din;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [CW-1:0]    counter;
   logic             start_q;
   logic             res_valid_q;
   logic             res_err_q;
   logic [WIDTH-1:0] res_max_q;
   logic             done_hit;
   logic             timeout_hit;

   // Neuron 1 sits in the lowest slot of every stored vector.
   assign fifo_din = {bus.in_neuron4, bus.in_neuron3, bus.in_neuron2, bus.in_neuron1};

   maxnet_vec_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.in_valid),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A new vector is taken only when the result slot is empty or is being
   // drained this very cycle, which keeps a single transaction in flight.
   assign fifo_pop = (state == IDLE) && !fifo_empty && (!res_valid_q || bus.res_ready);

   // Done outranks the timeout when both land on the final count.
   assign done_hit    = (state == WAIT) && bus.core_done;
   assign timeout_hit = (state == WAIT) && !bus.core_done && (counter == LAST_COUNT);

   // The core is held in reset during our own reset as well as for the one
   // CLR cycle, so an aborted transaction never leaves it half-finished.
   assign bus.core_rst   = reset || (state == CLR);
   assign bus.core_start = start_q;
   assign bus.in_ready   = !fifo_full;
   assign bus.Neuron1    = drive_vec[0*WIDTH +: WIDTH];
   assign bus.Neuron2    = drive_vec[1*WIDTH +: WIDTH];
   assign bus.Neuron3    = drive_vec[2*WIDTH +: WIDTH];
   assign bus.Neuron4    = drive_vec[3*WIDTH +: WIDTH];
   assign bus.res_valid  = res_valid_q;
   assign bus.res_err    = res_err_q;
   assign bus.res_max    = res_max_q;

   // Sequencing FSM with its registered outputs. Neuron values are loaded on
   // the CLR->SETUP edge and then left alone, so they stay stable through
   // WAIT and keep their last value while idle. start_q is set on the
   // SETUP->START edge, which makes it high for exactly the START cycle.
   // core_done is only looked at in WAIT, so a level left over from the
   // previous transaction cannot complete the next one early.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         vec_reg     <= '0;
         drive_vec   <= '0;
         counter     <= '0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_max_q   <= '0;
      end else begin
         start_q <= 1'b0;
         if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  vec_reg <= fifo_dout;
                  state   <= CLR;
               end
            end
            CLR: begin
               drive_vec <= vec_reg;
               state     <= SETUP;
            end
            SETUP: begin
               start_q <= 1'b1;
               state   <= START;
            end
            START: begin
               counter <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (done_hit) begin
                  res_max_q   <= bus.core_max;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state       <= IDLE;
               end else if (timeout_hit) begin
                  res_max_q   <= '0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state       <= IDLE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MAXNET_DRV_STATS_EN
   // Completion statistics: successes wrap, timeouts stick at their maximum.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_done_cnt    <= '0;
         stat_timeout_cnt <= '0;
      end else begin
         if (done_hit) begin
            stat_done_cnt <= stat_done_cnt + 1'b1;
         end
         if (timeout_hit && (stat_timeout_cnt != 8'hFF)) begin
            stat_timeout_cnt <= stat_timeout_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
